// File: rtl/ucie_ctl_fdi_lp_driver.sv
// rtl/ucie_ctl_fdi_lp_driver.sv - FDI protocol-layer driver: link sequencing, TX flit FIFO, RX flit register
module ucie_ctl_fdi_lp_driver #(
    parameter int NBYTES      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_link_en,
    input  logic                  i_linkerror_req,
    input  logic                  i_tx_valid,
    input  logic [NBYTES*8-1:0]   i_tx_data,
    output logic                  o_tx_ready,
    input  logic [3:0]            i_fdi_pl_state_sts,
    input  logic                  i_fdi_pl_inband_pres,
    input  logic                  i_fdi_pl_rx_active_req,
    input  logic                  i_fdi_pl_trdy,
    input  logic                  i_fdi_pl_valid,
    input  logic [NBYTES*8-1:0]   i_fdi_pl_data,
    output logic [3:0]            o_fdi_lp_state_req,
    output logic                  o_fdi_lp_rx_active_sts,
    output logic                  o_fdi_lp_linkerror,
    output logic                  o_fdi_lp_irdy,
    output logic                  o_fdi_lp_valid,
    output logic [NBYTES*8-1:0]   o_fdi_lp_data,
    output logic                  o_rx_valid,
    output logic [NBYTES*8-1:0]   o_rx_data,
    output logic                  o_rx_drop,
    output logic                  o_link_up,
    output logic                  o_timeout,
    output logic [15:0]           o_tx_count
);
    localparam int DW = NBYTES * 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [3:0] REQ_NOP       = 4'b0000;
    localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
    localparam logic [3:0] REQ_LINKRESET = 4'b1001;
    localparam logic [3:0] STS_RESET     = 4'b0000;
    localparam logic [3:0] STS_ACTIVE    = 4'b0001;
    localparam logic [3:0] STS_LINKERR   = 4'b1010;
    localparam logic [3:0] STS_RETRAIN   = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE, S_BRINGUP, S_ACTIVE, S_RETRAIN, S_TEARDOWN, S_ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic            timer_hit;
    logic            ready_en;
    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, empty, push, pop, flush;

    assign timer_hit = (timer == TMR_LAST);

    always_comb begin
        state_nxt = state;
        if (i_linkerror_req) begin
            state_nxt = S_ERROR;
        end else begin
            case (state)
                S_IDLE:     if (i_link_en && i_fdi_pl_inband_pres) state_nxt = S_BRINGUP;
                S_BRINGUP: begin
                    if (i_fdi_pl_state_sts == STS_ACTIVE) state_nxt = S_ACTIVE;
                    else if (timer_hit)                   state_nxt = S_ERROR;
                    else if (!i_link_en)                  state_nxt = S_IDLE;
                end
                S_ACTIVE: begin
                    if (i_fdi_pl_state_sts == STS_RETRAIN)      state_nxt = S_RETRAIN;
                    else if (i_fdi_pl_state_sts == STS_LINKERR) state_nxt = S_ERROR;
                    else if (!i_link_en)                        state_nxt = S_TEARDOWN;
                end
                S_RETRAIN: begin
                    if (i_fdi_pl_state_sts == STS_ACTIVE)       state_nxt = S_ACTIVE;
                    else if (i_fdi_pl_state_sts == STS_LINKERR) state_nxt = S_ERROR;
                end
                S_TEARDOWN: if (i_fdi_pl_state_sts == STS_RESET) state_nxt = S_IDLE;
                S_ERROR:    if (i_fdi_pl_state_sts == STS_RESET) state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                  <= S_IDLE;
            timer                  <= '0;
            o_timeout              <= 1'b0;
            o_fdi_lp_state_req     <= REQ_NOP;
            o_fdi_lp_linkerror     <= 1'b0;
            o_link_up              <= 1'b0;
            o_fdi_lp_rx_active_sts <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_BRINGUP && state != S_BRINGUP)
                timer <= '0;
            else if (state == S_BRINGUP && !timer_hit)
                timer <= timer + TMR_ONE;
            if (state == S_BRINGUP && timer_hit && i_fdi_pl_state_sts != STS_ACTIVE)
                o_timeout <= 1'b1;
            case (state_nxt)
                S_BRINGUP, S_ACTIVE, S_RETRAIN: o_fdi_lp_state_req <= REQ_ACTIVE;
                S_TEARDOWN:                     o_fdi_lp_state_req <= REQ_LINKRESET;
                default:                        o_fdi_lp_state_req <= REQ_NOP;
            endcase
            o_fdi_lp_linkerror     <= (state_nxt == S_ERROR);
            o_link_up              <= (state_nxt == S_ACTIVE);
            o_fdi_lp_rx_active_sts <= (state_nxt != S_ERROR) && i_fdi_pl_rx_active_req;
        end
    end

    assign full          = (count == CNT_FULL);
    assign empty         = (count == '0);
    assign o_tx_ready    = ready_en && !full;
    assign o_fdi_lp_irdy = (state == S_ACTIVE) && !empty;
    assign o_fdi_lp_valid = o_fdi_lp_irdy;
    assign o_fdi_lp_data = mem[rd_ptr];
    assign push          = i_tx_valid && o_tx_ready;
    assign pop           = o_fdi_lp_irdy && i_fdi_pl_trdy;
    assign flush         = (state_nxt == S_ERROR && state != S_ERROR) ||
                           (state_nxt == S_IDLE  && state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_tx_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            // A flit popped on the flush cycle has already left on the bus, so it is still counted.
            if (pop && o_tx_count != 16'hFFFF)
                o_tx_count <= o_tx_count + 16'd1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= i_tx_data;
                    wr_ptr      <= wr_ptr + PTR_ONE;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_valid <= 1'b0;
            o_rx_drop  <= 1'b0;
            o_rx_data  <= '0;
        end else begin
            o_rx_valid <= i_fdi_pl_valid && o_fdi_lp_rx_active_sts;
            o_rx_drop  <= i_fdi_pl_valid && !o_fdi_lp_rx_active_sts;
            if (i_fdi_pl_valid && o_fdi_lp_rx_active_sts)
                o_rx_data <= i_fdi_pl_data;
        end
    end
endmodule

// File: tb/tb_ucie_ctl_fdi_lp_driver.sv
// tb/tb_ucie_ctl_fdi_lp_driver.sv - self-checking bench for ucie_ctl_fdi_lp_driver
module tb_ucie_ctl_fdi_lp_driver;
    localparam int NB = 8, DEPTH = 4, TO = 16, DW = NB * 8;
    localparam logic [3:0] ST_RESET = 4'b0000, ST_ACTIVE = 4'b0001, ST_LINKERR = 4'b1010, ST_RETRAIN = 4'b1011;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          link_en = 0, linkerror_req = 0, tx_valid = 0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready;
    logic [3:0]    pl_sts = ST_RESET;
    logic          inband = 0, rx_req = 0, trdy = 0, pl_valid = 0;
    logic [DW-1:0] pl_data = '0;
    logic [3:0]    lp_req;
    logic          rx_sts, lp_linkerror, irdy, lp_valid;
    logic [DW-1:0] lp_data, rx_data;
    logic          rx_valid, rx_drop, link_up, timeout;
    logic [15:0]   tx_count;

    int checks = 0, failures = 0;
    logic [DW-1:0] fq[$];
    int exp_txc = 0;

    always #5 clk = ~clk;

    ucie_ctl_fdi_lp_driver #(.NBYTES(NB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_link_en(link_en), .i_linkerror_req(linkerror_req),
        .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
        .i_fdi_pl_state_sts(pl_sts), .i_fdi_pl_inband_pres(inband),
        .i_fdi_pl_rx_active_req(rx_req), .i_fdi_pl_trdy(trdy),
        .i_fdi_pl_valid(pl_valid), .i_fdi_pl_data(pl_data),
        .o_fdi_lp_state_req(lp_req), .o_fdi_lp_rx_active_sts(rx_sts),
        .o_fdi_lp_linkerror(lp_linkerror), .o_fdi_lp_irdy(irdy), .o_fdi_lp_valid(lp_valid),
        .o_fdi_lp_data(lp_data), .o_rx_valid(rx_valid), .o_rx_data(rx_data), .o_rx_drop(rx_drop),
        .o_link_up(link_up), .o_timeout(timeout), .o_tx_count(tx_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_active();
        link_en = 1; inband = 1; pl_sts = ST_ACTIVE;
        for (int i = 0; i < 20 && !link_up; i++) step();
        checks++;
        if (link_up !== 1'b1) begin failures++; $display("FAIL go_active link_up=%0b exp=1", link_up); end
    endtask

    task automatic push_flits(input int n);
        for (int i = 0; i < n; i++) begin
            tx_valid = 1; tx_data = {$urandom, $urandom};
            if (fq.size() < DEPTH) fq.push_back(tx_data);
            step();
        end
        tx_valid = 0;
    endtask

    task automatic drain(input string name);
        while (fq.size() != 0) begin
            checks++;
            if (irdy !== 1'b1 || lp_valid !== 1'b1 || lp_data !== fq[0]) begin
                failures++;
                $display("FAIL %s irdy=%0b valid=%0b data=%h exp_data=%h", name, irdy, lp_valid, lp_data, fq[0]);
            end
            step();
            void'(fq.pop_front());
            exp_txc++;
        end
        checks++;
        if (irdy !== 1'b0 || tx_count !== 16'(exp_txc)) begin
            failures++; $display("FAIL %s_end irdy=%0b tx_count=%0d exp_count=%0d", name, irdy, tx_count, exp_txc);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        step(); step();
        checks++;
        if ({lp_req, rx_sts, lp_linkerror, irdy, lp_valid, rx_valid, rx_drop, link_up, timeout, tx_ready} !== '0
            || lp_data !== '0 || rx_data !== '0 || tx_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs req=%h rx_sts=%0b err=%0b irdy=%0b rx_valid=%0b link_up=%0b timeout=%0b tx_ready=%0b count=%0d exp=all_zero",
                     lp_req, rx_sts, lp_linkerror, irdy, rx_valid, link_up, timeout, tx_ready, tx_count);
        end
        rst_n = 1;
        step();
        checks++;
        if (tx_ready !== 1'b1 || lp_req !== 4'h0) begin
            failures++; $display("FAIL reset_release tx_ready=%0b req=%h exp=1/0", tx_ready, lp_req);
        end
    endtask

    task automatic test_bringup();
        rx_req = 1; link_en = 1; inband = 1; pl_sts = ST_RESET;
        step();
        checks++;
        if (lp_req !== 4'b0001 || rx_sts !== 1'b1 || link_up !== 1'b0) begin
            failures++; $display("FAIL bringup_req req=%h rx_sts=%0b link_up=%0b exp=1/1/0", lp_req, rx_sts, link_up);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (link_up !== 1'b0 || lp_req !== 4'b0001) begin
            failures++; $display("FAIL bringup_wait link_up=%0b req=%h exp=0/1", link_up, lp_req);
        end
        pl_sts = ST_ACTIVE;
        step();
        checks++;
        if (link_up !== 1'b1) begin failures++; $display("FAIL bringup_active link_up=%0b exp=1", link_up); end
    endtask

    task automatic test_tx_backpressure();
        logic exp_rdy;
        trdy = 0;
        for (int i = 0; i < 6; i++) begin
            tx_valid = 1; tx_data = DW'(i + 1);
            exp_rdy = (fq.size() < DEPTH);
            checks++;
            if (tx_ready !== exp_rdy) begin
                failures++; $display("FAIL bp_ready push=%0d tx_ready=%0b exp=%0b", i, tx_ready, exp_rdy);
            end
            if (exp_rdy) fq.push_back(tx_data);
            step();
        end
        tx_valid = 0;
        checks++;
        if (tx_ready !== 1'b0 || irdy !== 1'b1) begin
            failures++; $display("FAIL bp_full tx_ready=%0b irdy=%0b exp=0/1", tx_ready, irdy);
        end
        trdy = 1;
        drain("bp_drain");
        checks++;
        if (tx_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after tx_ready=%0b exp=1", tx_ready); end
    endtask

    task automatic test_retrain();
        trdy = 0;
        push_flits(2);
        pl_sts = ST_RETRAIN;
        step();
        trdy = 1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (irdy !== 1'b0 || link_up !== 1'b0 || lp_req !== 4'b0001) begin
                failures++; $display("FAIL retrain_stall cyc=%0d irdy=%0b link_up=%0b req=%h exp=0/0/1", i, irdy, link_up, lp_req);
            end
            step();
        end
        pl_sts = ST_ACTIVE;
        step();
        drain("retrain_drain");
    endtask

    task automatic test_rx_gating();
        logic exp_sts, exp_v, exp_d;
        logic [DW-1:0] exp_data;
        rx_req = 0; pl_valid = 0;
        step();
        pl_valid = 1; pl_data = DW'(8'hAB);
        step();
        checks++;
        if (rx_drop !== 1'b1 || rx_valid !== 1'b0) begin
            failures++; $display("FAIL rx_drop drop=%0b valid=%0b exp=1/0", rx_drop, rx_valid);
        end
        pl_valid = 0; rx_req = 1;
        step();
        pl_valid = 1;
        step();
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== DW'(8'hAB) || rx_drop !== 1'b0) begin
            failures++; $display("FAIL rx_accept valid=%0b data=%h drop=%0b exp=1/ab/0", rx_valid, rx_data, rx_drop);
        end
        exp_sts = 1; exp_data = DW'(8'hAB);
        for (int i = 0; i < 30; i++) begin
            pl_valid = 1'($urandom); rx_req = 1'($urandom); pl_data = {$urandom, $urandom};
            exp_v = pl_valid && exp_sts;
            exp_d = pl_valid && !exp_sts;
            if (exp_v) exp_data = pl_data;
            exp_sts = rx_req;
            step();
            checks++;
            if ({rx_valid, rx_drop, rx_sts} !== {exp_v, exp_d, exp_sts} || rx_data !== exp_data) begin
                failures++;
                $display("FAIL rx_random cyc=%0d valid/drop/sts=%b%b%b exp=%b%b%b data=%h exp_data=%h",
                         i, rx_valid, rx_drop, rx_sts, exp_v, exp_d, exp_sts, rx_data, exp_data);
            end
        end
        pl_valid = 0; rx_req = 1;
        step();
    endtask

    task automatic test_link_error();
        trdy = 0;
        push_flits(2);
        linkerror_req = 1;
        step();
        linkerror_req = 0;
        fq.delete();
        checks++;
        if (lp_linkerror !== 1'b1 || rx_sts !== 1'b0 || irdy !== 1'b0 || link_up !== 1'b0 || lp_req !== 4'h0) begin
            failures++; $display("FAIL linkerr_enter err=%0b rx_sts=%0b irdy=%0b link_up=%0b req=%h exp=1/0/0/0/0",
                                 lp_linkerror, rx_sts, irdy, link_up, lp_req);
        end
        step(); step();
        checks++;
        if (lp_linkerror !== 1'b1) begin failures++; $display("FAIL linkerr_hold err=%0b exp=1", lp_linkerror); end
        pl_sts = ST_RESET;
        step();
        checks++;
        if (lp_linkerror !== 1'b0) begin failures++; $display("FAIL linkerr_exit err=%0b exp=0", lp_linkerror); end
        go_active();
        checks++;
        if (irdy !== 1'b0 || tx_ready !== 1'b1 || tx_count !== 16'(exp_txc)) begin
            failures++; $display("FAIL linkerr_flush irdy=%0b tx_ready=%0b count=%0d exp=0/1/%0d", irdy, tx_ready, tx_count, exp_txc);
        end
    endtask

    task automatic test_teardown();
        link_en = 0;
        step(); step();
        checks++;
        if (lp_req !== 4'b1001 || link_up !== 1'b0) begin
            failures++; $display("FAIL teardown_req req=%h link_up=%0b exp=9/0", lp_req, link_up);
        end
        pl_sts = ST_RESET;
        step(); step();
        checks++;
        if (lp_req !== 4'b0000) begin failures++; $display("FAIL teardown_idle req=%h exp=0", lp_req); end
    endtask

    task automatic test_timeout();
        pl_sts = ST_RESET; link_en = 1; inband = 1;
        step();
        for (int k = 1; k <= TO - 1; k++) begin
            step();
            checks++;
            if (timeout !== 1'b0 || lp_linkerror !== 1'b0 || lp_req !== 4'b0001) begin
                failures++; $display("FAIL timeout_early cyc=%0d timeout=%0b err=%0b req=%h exp=0/0/1", k, timeout, lp_linkerror, lp_req);
            end
        end
        step();
        checks++;
        if (timeout !== 1'b1 || lp_linkerror !== 1'b1 || lp_req !== 4'h0) begin
            failures++; $display("FAIL timeout_hit timeout=%0b err=%0b req=%h exp=1/1/0", timeout, lp_linkerror, lp_req);
        end
        link_en = 0;
        step(); step();
        checks++;
        if (timeout !== 1'b1 || lp_linkerror !== 1'b0) begin
            failures++; $display("FAIL timeout_sticky timeout=%0b err=%0b exp=1/0", timeout, lp_linkerror);
        end
    endtask

    task automatic test_async_reset();
        go_active();
        trdy = 0;
        push_flits(2);
        trdy = 1;
        step();
        trdy = 0;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        checks++;
        if ({lp_req, rx_sts, lp_linkerror, irdy, link_up, timeout, tx_ready} !== '0 || tx_count !== 16'd0 || lp_data !== '0) begin
            failures++; $display("FAIL async_reset req=%h irdy=%0b link_up=%0b timeout=%0b tx_ready=%0b count=%0d exp=all_zero",
                                 lp_req, irdy, link_up, timeout, tx_ready, tx_count);
        end
        fq.delete(); exp_txc = 0;
        link_en = 0; inband = 0;
        step();
        rst_n = 1;
        step();
        checks++;
        if (tx_ready !== 1'b1 || timeout !== 1'b0 || irdy !== 1'b0) begin
            failures++; $display("FAIL async_release tx_ready=%0b timeout=%0b irdy=%0b exp=1/0/0", tx_ready, timeout, irdy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bringup();
        test_tx_backpressure();
        test_retrain();
        test_rx_gating();
        test_link_error();
        test_teardown();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
